// File: rtl/alu_exec_if.sv
// rtl/alu_exec_if.sv - request/result handshake bundle for the execute-stage ALU
interface alu_exec_if #(parameter int WIDTH = 32);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       alu_ctl;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             overflow;
    logic             illegal;

    modport master (
        output in_valid, alu_ctl, op_a, op_b, out_ready,
        input  in_ready, out_valid, result, zero, overflow, illegal
    );

    modport slave (
        input  in_valid, alu_ctl, op_a, op_b, out_ready,
        output in_ready, out_valid, result, zero, overflow, illegal
    );
endinterface

// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - execute-stage ALU, single-cycle logic/arith ops plus iterative shift-add multiply
module alu_exec_unit #(
    parameter int WIDTH = 32
) (
    input  logic      clk,
    input  logic      reset,
    alu_exec_if.slave bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic [3:0] CTL_AND = 4'b0000;
    localparam logic [3:0] CTL_OR  = 4'b0001;
    localparam logic [3:0] CTL_ADD = 4'b0010;
    localparam logic [3:0] CTL_SUB = 4'b0110;
    localparam logic [3:0] CTL_SLT = 4'b0111;
    localparam logic [3:0] CTL_MUL = 4'b1000;

    typedef enum logic {IDLE, MUL_BUSY} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] mcand_q, mplier_q, acc_q;
    logic [CW-1:0]    cnt_q;
    logic             out_valid_q, zero_q, overflow_q, illegal_q;
    logic [WIDTH-1:0] result_q;

    logic             accept, is_mul, mul_last;
    logic [WIDTH-1:0] sum, diff, acc_step, single_res;
    logic             add_ovf, sub_ovf, single_ovf, single_ill;

    assign bus.in_ready  = (state_q == IDLE) && (!out_valid_q || bus.out_ready) && !reset;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.zero      = zero_q;
    assign bus.overflow  = overflow_q;
    assign bus.illegal   = illegal_q;

    assign accept   = bus.in_valid && bus.in_ready;
    assign is_mul   = (bus.alu_ctl == CTL_MUL);
    assign mul_last = (cnt_q == CW'(WIDTH - 1));
    assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);

    assign sum     = bus.op_a + bus.op_b;
    assign diff    = bus.op_a - bus.op_b;
    assign add_ovf = (bus.op_a[WIDTH-1] == bus.op_b[WIDTH-1]) && (sum[WIDTH-1] != bus.op_a[WIDTH-1]);
    assign sub_ovf = (bus.op_a[WIDTH-1] != bus.op_b[WIDTH-1]) && (diff[WIDTH-1] != bus.op_a[WIDTH-1]);

    always_comb begin
        single_res = '0;
        single_ovf = 1'b0;
        single_ill = 1'b0;
        case (bus.alu_ctl)
            CTL_AND: single_res = bus.op_a & bus.op_b;
            CTL_OR:  single_res = bus.op_a | bus.op_b;
            CTL_ADD: begin
                single_res = sum;
                single_ovf = add_ovf;
            end
            CTL_SUB: begin
                single_res = diff;
                single_ovf = sub_ovf;
            end
            CTL_SLT: single_res = {{(WIDTH-1){1'b0}}, diff[WIDTH-1] ^ sub_ovf};
            default: single_ill = 1'b1;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (accept && is_mul) state_d = MUL_BUSY;
            MUL_BUSY: if (mul_last) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            overflow_q  <= 1'b0;
            illegal_q   <= 1'b0;
        end else if (state_q == MUL_BUSY) begin
            // one shift-add step per cycle; the final step lands straight in the result
            acc_q    <= acc_step;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + CW'(1);
            if (mul_last) begin
                out_valid_q <= 1'b1;
                result_q    <= acc_step;
                zero_q      <= (acc_step == '0);
                overflow_q  <= 1'b0;
                illegal_q   <= 1'b0;
            end
        end else if (accept) begin
            if (is_mul) begin
                mcand_q     <= bus.op_a;
                mplier_q    <= bus.op_b;
                acc_q       <= '0;
                cnt_q       <= '0;
                out_valid_q <= 1'b0;
            end else begin
                out_valid_q <= 1'b1;
                result_q    <= single_res;
                zero_q      <= (single_res == '0);
                overflow_q  <= single_ovf;
                illegal_q   <= single_ill;
            end
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb/tb_alu_exec_unit.sv - directed self-checking bench for alu_exec_unit
module tb_alu_exec_unit;
    logic clk = 1'b0;
    logic reset;
    int   n_chk  = 0;
    int   n_fail = 0;
    logic seen;

    alu_exec_if #(.WIDTH(32)) bus ();

    alu_exec_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [3:0] ctl, input logic [31:0] a, input logic [31:0] b);
        bus.in_valid = 1'b1;
        bus.alu_ctl  = ctl;
        bus.op_a     = a;
        bus.op_b     = b;
    endtask

    task automatic chk_out(input string tag, input logic [31:0] res,
                           input logic z, input logic ov, input logic il);
        chk({tag, ".out_valid"}, bus.out_valid, 1'b1);
        chk({tag, ".result"},    bus.result,    res);
        chk({tag, ".zero"},      bus.zero,      z);
        chk({tag, ".overflow"},  bus.overflow,  ov);
        chk({tag, ".illegal"},   bus.illegal,   il);
    endtask

    initial begin
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.alu_ctl   = 4'b0000;
        bus.op_a      = '0;
        bus.op_b      = '0;
        bus.out_ready = 1'b1;
        tick();
        tick();
        chk("rst.in_ready",  bus.in_ready,  1'b0);
        chk("rst.out_valid", bus.out_valid, 1'b0);
        chk("rst.result",    bus.result,    32'h0);
        chk("rst.zero",      bus.zero,      1'b0);
        chk("rst.overflow",  bus.overflow,  1'b0);
        chk("rst.illegal",   bus.illegal,   1'b0);
        reset = 1'b0;
        #1;
        chk("idle.in_ready", bus.in_ready, 1'b1);

        // back-to-back single-cycle ops, one per edge
        issue(4'b0010, 32'h7FFF_FFFF, 32'h0000_0001);
        tick();
        chk_out("add_ovf", 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        issue(4'b0110, 32'd5, 32'd5);
        tick();
        chk_out("sub_zero", 32'h0, 1'b1, 1'b0, 1'b0);
        issue(4'b0110, 32'h8000_0000, 32'h0000_0001);
        tick();
        chk_out("sub_ovf", 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0);
        issue(4'b0001, 32'h0000_00F0, 32'h0000_000F);
        tick();
        chk_out("or", 32'h0000_00FF, 1'b0, 1'b0, 1'b0);
        issue(4'b0111, 32'h8000_0000, 32'h0000_0001);
        tick();
        chk_out("slt_neg", 32'h1, 1'b0, 1'b0, 1'b0);
        issue(4'b0111, 32'h7FFF_FFFF, 32'hFFFF_FFFF);
        tick();
        chk_out("slt_pos", 32'h0, 1'b1, 1'b0, 1'b0);
        bus.in_valid = 1'b0;
        tick();
        chk("drain.out_valid", bus.out_valid, 1'b0);

        // backpressure, then same-edge drain + accept
        bus.out_ready = 1'b0;
        issue(4'b0010, 32'd3, 32'd4);
        tick();
        issue(4'b0000, 32'h0000_00F0, 32'h0000_003C);
        for (int i = 0; i < 5; i++) begin
            chk("bp.in_ready",  bus.in_ready,  1'b0);
            chk("bp.out_valid", bus.out_valid, 1'b1);
            chk("bp.result",    bus.result,    32'd7);
            tick();
        end
        bus.out_ready = 1'b1;
        #1;
        chk("bp_release.in_ready", bus.in_ready, 1'b1);
        tick();
        bus.in_valid = 1'b0;
        chk_out("and", 32'h0000_0030, 1'b0, 1'b0, 1'b0);

        // illegal codes are consumed without stalling
        issue(4'b1111, 32'd7, 32'd9);
        tick();
        bus.in_valid = 1'b0;
        chk_out("ill_f", 32'h0, 1'b1, 1'b0, 1'b1);
        tick();
        chk("ill_f.drain", bus.out_valid, 1'b0);
        issue(4'b0011, 32'd1, 32'd1);
        tick();
        bus.in_valid = 1'b0;
        chk_out("ill_3", 32'h0, 1'b1, 1'b0, 1'b1);

        // multiply, with in_valid held high and operands scrambled while busy
        issue(4'b1000, 32'h0001_2345, 32'h0000_0010);
        tick();
        issue(4'b0010, 32'hDEAD_BEEF, 32'h1234_5678);
        chk("mul0.out_valid", bus.out_valid, 1'b0);
        for (int c = 1; c < 32; c++) begin
            chk("mul_busy.in_ready", bus.in_ready, 1'b0);
            tick();
            chk("mul_busy.out_valid", bus.out_valid, 1'b0);
        end
        bus.in_valid = 1'b0;
        tick();
        chk_out("mul_a", 32'h0012_3450, 1'b0, 1'b0, 1'b0);

        issue(4'b1000, 32'hFFFF_FFFF, 32'h0000_0002);
        tick();
        bus.in_valid = 1'b0;
        repeat (31) tick();
        chk("mul_b.early", bus.out_valid, 1'b0);
        tick();
        chk_out("mul_b", 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);

        issue(4'b1000, 32'h0001_0000, 32'h0001_0000);
        tick();
        bus.in_valid = 1'b0;
        repeat (32) tick();
        chk_out("mul_wrap0", 32'h0, 1'b1, 1'b0, 1'b0);

        // reset during a multiply discards it
        issue(4'b1000, 32'd3, 32'd5);
        tick();
        bus.in_valid = 1'b0;
        repeat (10) tick();
        reset = 1'b1;
        #1;
        chk("rst_mul.in_ready_hi", bus.in_ready, 1'b0);
        tick();
        chk("rst_mul.out_valid", bus.out_valid, 1'b0);
        chk("rst_mul.result",    bus.result,    32'h0);
        reset = 1'b0;
        #1;
        chk("rst_mul.in_ready", bus.in_ready, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.out_valid !== 1'b0) seen = 1'b1;
        end
        chk("rst_mul.no_result", seen, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execute-stage ALU that consumes the 4-bit ALU control code produced by the ALU control decoder, together with two operands.
- Returns a registered result, zero, overflow and illegal-code flags.
- Single-cycle ops use a valid/ready handshake; multiply is iterative and multi-cycle.
- Sits between ID/EX and EX/MEM in the pipelined CPU; the hazard unit stalls on in_ready=0.

Parameters:
WIDTH, 32, operand/result width in bits (>=8)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
in_valid  input  1  operation request valid
in_ready  output  1  unit can accept a request this cycle
alu_ctl  input  4  control code: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1000 MUL, others illegal (1111 = decoder "invalid")
op_a  input  WIDTH  operand A
op_b  input  WIDTH  operand B
out_valid  output  1  result registers hold an undelivered result
out_ready  input  1  consumer accepts the result this cycle
result  output  WIDTH  registered result
zero  output  1  result == 0
overflow  output  1  signed overflow (ADD/SUB only, else 0)
illegal  output  1  delivered result came from an illegal code

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Reset values: state=IDLE, out_valid=0, result=0, zero=0, overflow=0, illegal=0. in_ready=0 while reset is high.
- Reset mid-multiply aborts the operation; no result is ever delivered for it.
- States: IDLE, MUL_BUSY.
- in_ready is combinational: (state==IDLE) && (!out_valid || out_ready) && !reset.
- Accept condition: in_valid && in_ready on a rising edge. A simultaneous accept and output drain is legal, so back-to-back throughput is 1 op/cycle.
- Single-cycle ops (AND, OR, ADD, SUB, SLT, illegal), accepted at edge k: result and flags update at edge k, and out_valid=1 from edge k.
- ADD/SUB wrap modulo 2^WIDTH.
  - overflow = operand signs equal (ADD) or differ (SUB) and result sign differs from op_a.
- SLT is a signed comparison: result = {0..0, (a-b)[MSB] XOR ovf(a-b)}; overflow=0.
- Illegal code: result=0, zero=1, overflow=0, illegal=1, out_valid=1. The code is still consumed; no stall.
- MUL, accepted at edge k:
  - Latch operands; clear the accumulator; state becomes MUL_BUSY with iteration counter=0; out_valid=0.
  - Each BUSY cycle does one shift-add step (LSB of multiplier).
  - After WIDTH steps, at edge k+WIDTH: state=IDLE, result = low WIDTH bits of the unsigned product, zero updated, overflow=0, illegal=0, out_valid=1. Latency is WIDTH cycles.
  - in_ready=0 throughout MUL_BUSY; in_valid is ignored.
- Backpressure: while out_valid && !out_ready, result and all flags hold stable and in_ready=0.
- Output drain: out_valid clears at an edge with out_ready=1 and no new single-cycle accept.
- Operand stability: op_a, op_b and alu_ctl are sampled only at the accept edge; later changes do not affect an in-flight MUL.
- Counter wrap: the iteration counter is ceil(log2(WIDTH))+1 bits. It terminates exactly at WIDTH and is reset on every MUL accept.

Test Plan:
- ADD 0x7FFFFFFF+0x00000001, out_ready=1 -> next cycle result=0x80000000, overflow=1, zero=0. SUB 5-5 -> result=0, zero=1, overflow=0.
- SLT a=0x80000000, b=0x00000001 -> result=1. SLT a=0x7FFFFFFF, b=0xFFFFFFFF -> result=0; overflow=0 in both.
- Backpressure: ADD 3+4 accepted, out_ready=0 for 5 cycles -> result=7 stable, in_ready=0. Raise out_ready with a new AND 0xF0&0x3C pending -> same-edge drain+accept, next result=0x30.
- MUL 0x00012345*0x00000010 accepted at cycle 0 -> in_ready=0 cycles 1..31, out_valid=1 at cycle 32, result=0x00123450. MUL 0xFFFFFFFF*2 -> 0xFFFFFFFE.
- alu_ctl=1111, op_a=7, op_b=9 -> result=0, illegal=1, zero=1, out_valid for one cycle with out_ready=1.
- Reset asserted at MUL cycle 10 -> next cycle out_valid=0, result=0, state IDLE. No result appears afterwards; in_ready=1 the first cycle reset is low.
